mul_div_unit: RTL and testbench

Iterative 16-bit unsigned multiply/divide unit sitting directly downstream of the register file read ports, alongside the single-cycle ALU. It takes the two operands read for an instruction, runs a shift-add multiply or restoring divide over WIDTH cycles, and returns a result plus destination register address. The decoder uses these to drive the register file write data and global write enable. A start/busy/done handshake lets the control unit stall the core while an operation is in flight.

---
 rtl/mul_div_unit_pkg.sv | 19 +
 rtl/mul_div_if.sv | 30 +++
 rtl/mul_div_unit.sv | 148 ++++++++++++++
 tb/tb_mul_div_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
package mul_div_unit_pkg;

    localparam int unsigned DEF_WIDTH      = 16;
    localparam int unsigned DEF_REG_ADDR_W = 4;

    // Operation encoding presented on op.
    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_REM  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul_div_if.sv
// Request/response bundle between the control unit and the multiply/divide unit.
interface mul_div_if
    import mul_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
);

    logic                  start;
    logic [1:0]            op;
    logic [WIDTH-1:0]      opa;
    logic [WIDTH-1:0]      opb;
    logic [REG_ADDR_W-1:0] rd_in;
    logic                  busy;
    logic                  done;
    logic [WIDTH-1:0]      result;
    logic [REG_ADDR_W-1:0] rd_out;
    logic                  div_by_zero;

    modport master (
        output start, op, opa, opb, rd_in,
        input  busy, done, result, rd_out, div_by_zero
    );

    modport slave (
        input  start, op, opa, opb, rd_in,
        output busy, done, result, rd_out, div_by_zero
    );

endinterface

// File: rtl/mul_div_unit.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic     clk,
    input  logic     rst,
    mul_div_if.slave mdu
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            op_q, op_d;
    logic [WIDTH-1:0]      a_q, a_d;
    logic [WIDTH-1:0]      b_q, b_d;
    logic [WIDTH-1:0]      hi_q, hi_d;
    logic [WIDTH-1:0]      lo_q, lo_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [REG_ADDR_W-1:0] rd_out_q, rd_out_d;
    logic [WIDTH-1:0]      result_q, result_d;
    logic                  dbz_q, dbz_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  is_div;
    logic                  sel_hi;
    logic [WIDTH:0]        mul_sum;
    logic [WIDTH:0]        div_shift;
    logic [WIDTH-1:0]      div_sub;
    logic                  div_ok;
    logic [WIDTH-1:0]      step_hi;
    logic [WIDTH-1:0]      step_lo;

    // Shared datapath: hi holds product-high / partial remainder, lo holds multiplier / quotient.
    assign is_div    = (op_q == OP_DIV) || (op_q == OP_REM);
    assign sel_hi    = (op_q == OP_MULH) || (op_q == OP_REM);
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    // Only used when no borrow, where the true difference fits in WIDTH bits.
    assign div_sub   = div_shift[WIDTH-1:0] - b_q;
    assign div_ok    = (div_shift >= {1'b0, b_q});
    assign step_hi   = is_div ? (div_ok ? div_sub : div_shift[WIDTH-1:0])
                              : mul_sum[WIDTH:1];
    assign step_lo   = is_div ? {lo_q[WIDTH-2:0], div_ok}
                              : {mul_sum[0], lo_q[WIDTH-1:1]};

    // Next-state, iteration and output-capture logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        rd_d     = rd_q;
        rd_out_d = rd_out_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (mdu.start) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    op_d    = mdu.op;
                    a_d     = mdu.opa;
                    b_d     = mdu.opb;
                    rd_d    = mdu.rd_in;
                    hi_d    = '0;
                    // Divide shifts the dividend out of lo; multiply shifts the multiplier.
                    lo_d    = mdu.op[1] ? mdu.opa : mdu.opb;
                end
            end
            ST_RUN: begin
                hi_d = step_hi;
                lo_d = step_lo;
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    result_d = sel_hi ? step_hi : step_lo;
                    rd_out_d = rd_q;
                    dbz_d    = is_div && (b_q == '0);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            rd_q     <= '0;
            rd_out_q <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            rd_q     <= rd_d;
            rd_out_q <= rd_out_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign mdu.busy        = busy_q;
    assign mdu.done        = done_q;
    assign mdu.result      = result_q;
    assign mdu.rd_out      = rd_out_q;
    assign mdu.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed vectors, monitor checks every done pulse.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mul_div_if #(.WIDTH(16), .REG_ADDR_W(4)) mif ();

    mul_div_unit #(.WIDTH(16), .REG_ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .mdu (mif)
    );

    typedef struct {
        logic [15:0] res;
        logic [3:0]  rd;
        logic        dbz;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mif.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, 32'(mif.result), 32'(e.res));
                check({e.name, "_rd_out"}, 32'(mif.rd_out), 32'(e.rd));
                check({e.name, "_dbz"}, 32'(mif.div_by_zero), 32'(e.dbz));
            end
        end
    end

    // Present a request for one cycle, then scramble inputs to prove they were captured.
    task automatic drive_req(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                             input logic [3:0] r);
        @(negedge clk);
        mif.start = 1'b1;
        mif.op    = o;
        mif.opa   = a;
        mif.opb   = b;
        mif.rd_in = r;
        @(posedge clk);
        #1;
        mif.start = 1'b0;
        mif.op    = ~o;
        mif.opa   = ~a;
        mif.opb   = ~b;
        mif.rd_in = ~r;
    endtask

    // Count edges from the accepting edge until done is seen, and busy cycles on the way.
    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (lat <= 40) begin
            @(negedge clk);
            if (mif.busy) bc++;
            if (mif.done) break;
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] r,
                          input logic [15:0] res, input logic dbz);
        int lat;
        int bc;
        sb.push_back('{res, r, dbz, name});
        drive_req(o, a, b, r);
        wait_done(lat, bc);
        check({name, "_latency"}, 32'(lat), 32'd16);
        check({name, "_busy_cycles"}, 32'(bc), 32'd17);
        @(negedge clk);
        check({name, "_busy_after"}, 32'(mif.busy), 32'd0);
        check({name, "_result_hold"}, 32'(mif.result), 32'(res));
        check({name, "_rd_hold"}, 32'(mif.rd_out), 32'(r));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"}, 32'(mif.busy), 32'd0);
        check({name, "_done"}, 32'(mif.done), 32'd0);
        check({name, "_result"}, 32'(mif.result), 32'd0);
        check({name, "_rd_out"}, 32'(mif.rd_out), 32'd0);
        check({name, "_dbz"}, 32'(mif.div_by_zero), 32'd0);
    endtask

    task automatic count_dones(input int cycles, output int nd, output int nb);
        nd = 0;
        nb = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (mif.done) nd++;
            if (mif.busy) nb++;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        int nb;
        int cnt;

        rst       = 1'b1;
        mif.start = 1'b0;
        mif.op    = OP_MUL;
        mif.opa   = '0;
        mif.opb   = '0;
        mif.rd_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        run_op("mul_3x5",    OP_MUL,  16'h0003, 16'h0005, 4'd4,  16'h000F, 1'b0);
        run_op("mul_ffff",   OP_MUL,  16'hFFFF, 16'hFFFF, 4'd1,  16'h0001, 1'b0);
        run_op("mulh_ffff",  OP_MULH, 16'hFFFF, 16'hFFFF, 4'd15, 16'hFFFE, 1'b0);
        run_op("mul_1234",   OP_MUL,  16'h1234, 16'h5678, 4'd6,  16'h0060, 1'b0);
        run_op("mulh_1234",  OP_MULH, 16'h1234, 16'h5678, 4'd7,  16'h0626, 1'b0);
        run_op("div_100_7",  OP_DIV,  16'h0064, 16'h0007, 4'd3,  16'h000E, 1'b0);
        run_op("rem_100_7",  OP_REM,  16'h0064, 16'h0007, 4'd8,  16'h0002, 1'b0);
        run_op("div_by_0",   OP_DIV,  16'h1234, 16'h0000, 4'd10, 16'hFFFF, 1'b1);
        run_op("rem_by_0",   OP_REM,  16'h1234, 16'h0000, 4'd11, 16'h1234, 1'b1);
        run_op("div_ffff_1", OP_DIV,  16'hFFFF, 16'h0001, 4'd12, 16'hFFFF, 1'b0);
        run_op("rem_5_ffff", OP_REM,  16'h0005, 16'hFFFF, 4'd13, 16'h0005, 1'b0);

        // Start pulses while busy (mid-run and during DONE) must be ignored.
        sb.push_back('{16'h1230, 4'd2, 1'b0, "ignore"});
        drive_req(OP_MUL, 16'h0123, 16'h0010, 4'd2);
        repeat (5) @(posedge clk);
        @(negedge clk);
        mif.start = 1'b1;
        mif.op    = OP_DIV;
        mif.opa   = 16'hFFFF;
        mif.opb   = 16'h0001;
        mif.rd_in = 4'd9;
        @(negedge clk);
        mif.start = 1'b0;
        cnt = 0;
        while (!mif.done && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check("ignore_done_seen", 32'(mif.done), 32'd1);
        mif.start = 1'b1;
        @(negedge clk);
        mif.start = 1'b0;
        count_dones(30, nd, nb);
        check("ignore_extra_dones", 32'(nd), 32'd0);
        check("ignore_busy_after", 32'(nb), 32'd0);

        // Reset in the middle of a divide aborts it with no done pulse.
        drive_req(OP_DIV, 16'h0064, 16'h0007, 4'd5);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", 32'(mif.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        rst = 1'b0;
        count_dones(30, nd, nb);
        check("abort_no_done", 32'(nd), 32'd0);
        check("abort_no_busy", 32'(nb), 32'd0);

        // Start coinciding with reset is dropped.
        @(negedge clk);
        rst       = 1'b1;
        mif.start = 1'b1;
        mif.op    = OP_MUL;
        mif.opa   = 16'h0002;
        mif.opb   = 16'h0002;
        mif.rd_in = 4'd1;
        @(negedge clk);
        rst       = 1'b0;
        mif.start = 1'b0;
        check("rst_start_busy", 32'(mif.busy), 32'd0);
        @(negedge clk);
        check("rst_start_busy_next", 32'(mif.busy), 32'd0);

        run_op("mul_after_rst", OP_MUL, 16'h0010, 16'h0010, 4'd3, 16'h0100, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
